// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   InitialPc / ZeroWord / NopInst : reset and idle values
//   InstBusWidth / InstAddrBusWidth : instruction and address bus widths
//   fetch_entry_t                   : one queued {pc, inst} pair
package if_stage_pkg;

  localparam int unsigned InstBusWidth     = 32;
  localparam int unsigned InstAddrBusWidth = 32;

  localparam logic [InstAddrBusWidth-1:0] InitialPc = 32'h0000_0000;
  localparam logic [InstAddrBusWidth-1:0] ZeroWord  = 32'h0000_0000;
  localparam logic [InstBusWidth-1:0]     NopInst   = 32'h0000_0000;

  typedef struct packed {
    logic [InstAddrBusWidth-1:0] pc;
    logic [InstBusWidth-1:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// In-order {pc, inst} queue for the fetch stage.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : drop every entry (overrides trunc/push/pop)
//   trunc_i       : keep only the first keep_i entries, applied before push/pop
//   push_i        : append push_data_i at the tail
//   pop_i         : remove the head
//   head_o        : current head entry (registered storage)
//   count_o       : number of valid entries
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   trunc_i,
  input  logic [$clog2(Depth):0] keep_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_idx;
  logic [PtrW:0]   cnt_q, cnt_d, eff_cnt;

  always_comb begin
    eff_cnt = cnt_q;
    if (trunc_i && (keep_i < cnt_q)) eff_cnt = keep_i;
    // Tail slot follows the (possibly truncated) contents; wraps onto the
    // head slot when full, which is safe because the head is popped this cycle.
    wr_idx   = rd_ptr_q + eff_cnt[PtrW-1:0];
    rd_ptr_d = rd_ptr_q;
    cnt_d    = eff_cnt;
    if (clear_i) begin
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d    = cnt_d - (PtrW+1)'(1);
      end
      if (push_i) cnt_d = cnt_d + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i && push_i) mem_q[wr_idx] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, synchronous imem request, in-order
// {pc, inst} queue towards decode, branch redirect and controller flush.
// Build option: IF_DELAY_SLOT_EN selects MIPS delay-slot redirect semantics;
// without it a taken branch discards everything younger and fetches the target.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   imem_ce_o / imem_addr_o      : fetch request and word address
//   imem_rdata_i                 : instruction, one cycle after the request
//   id_valid_o/id_pc_o/id_inst_o : presented instruction (zeroed when invalid)
//   id_ready_i                   : decode accepts the presented instruction
//   branch_flag_i / branch_target_address_i : taken branch on the popped entry
//   flush_i / flush_pc_i         : full restart from flush_pc_i
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = InitialPc,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_ce_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic [31:0]     fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            kill_q, kill_d;
  logic            pend_q, pend_d;
  logic [31:0]     pend_target_q, pend_target_d;

  logic [CntW-1:0] count;
  logic [CntW:0]   occ;
  fetch_entry_t    head, push_data;
  logic            issue, pop, live_ret, push, clear, trunc, branch_take;
  logic [CntW-1:0] keep;

  if_fifo #(
    .Depth(QDEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .trunc_i    (trunc),
    .keep_i     (keep),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign id_valid_o  = (count != '0);
  assign id_pc_o     = id_valid_o ? head.pc : ZeroWord;
  assign id_inst_o   = id_valid_o ? head.inst : NopInst;
  assign pop         = id_valid_o && id_ready_i;
  assign branch_take = pop && branch_flag_i && !flush_i;

  // Killed in-flight words still occupy a slot, which keeps the bound simple.
  assign occ       = (CntW+1)'(count) + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
  assign issue     = !rst && (occ < (CntW+1)'(QDEPTH));
  assign imem_ce_o = issue;
  assign imem_addr_o = fpc_q;

  assign live_ret       = inflight_q && !kill_q;
  assign push_data.pc   = inflight_pc_q;
  assign push_data.inst = imem_rdata_i;

  always_comb begin
    fpc_d         = fpc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    inflight_d    = issue;
    inflight_pc_d = fpc_q;
    kill_d        = 1'b0;
    push          = live_ret;
    clear         = 1'b0;
    trunc         = 1'b0;
    keep          = '0;

    if (issue) begin
      if (pend_q) begin
        fpc_d  = pend_target_q;
        pend_d = 1'b0;
      end else begin
        fpc_d = fpc_q + 32'd4;
      end
    end

    if (flush_i) begin
      clear  = 1'b1;
      push   = 1'b0;
      kill_d = 1'b1;
      fpc_d  = flush_pc_i;
      pend_d = 1'b0;
    end else if (branch_take) begin
`ifdef IF_DELAY_SLOT_EN
      pend_d = 1'b0;
      if (count > CntW'(1)) begin
        // Slot is queued behind the branch: keep branch + slot only.
        trunc  = 1'b1;
        keep   = CntW'(2);
        push   = 1'b0;
        kill_d = 1'b1;
        fpc_d  = branch_target_address_i;
      end else if (live_ret) begin
        // Slot is returning now and gets pushed; anything issued now is younger.
        kill_d = 1'b1;
        fpc_d  = branch_target_address_i;
      end else if (issue) begin
        // The word issued this cycle is the slot itself.
        fpc_d = branch_target_address_i;
      end else begin
        fpc_d         = head.pc + 32'd4;
        pend_d        = 1'b1;
        pend_target_d = branch_target_address_i;
      end
`else
      clear  = 1'b1;
      push   = 1'b0;
      kill_d = 1'b1;
      fpc_d  = branch_target_address_i;
      pend_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= ZeroWord;
      kill_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= ZeroWord;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_ce_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  int unsigned  nvec = 0;
  int unsigned  nmis = 0;
  logic [31:0]  sb[$];
  logic         mon_en = 1'b1;
  logic         saw_200 = 1'b0;
  logic         done = 1'b0;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .QDEPTH  (2)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .imem_ce_o              (imem_ce_o),
    .imem_addr_o            (imem_addr_o),
    .imem_rdata_i           (imem_rdata_i),
    .id_valid_o             (id_valid_o),
    .id_pc_o                (id_pc_o),
    .id_inst_o              (id_inst_o),
    .id_ready_i             (id_ready_i),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .flush_i                (flush_i),
    .flush_pc_i             (flush_pc_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) imem_rdata_i <= imem_ce_o ? inst_of(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted instruction against the scoreboard.
  always @(negedge clk) begin
    if (imem_ce_o && imem_addr_o == 32'h200) saw_200 <= 1'b1;
    if (mon_en && !rst && id_valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_pop: got pc %h, expected none", id_pc_o);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb.pop_front();
        chk("pop_pc", id_pc_o, exp_pc);
        chk("pop_inst", id_inst_o, inst_of(exp_pc));
      end
    end
  end

  initial begin
    rst = 1'b1;
    id_ready_i = 1'b1;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    flush_i = 1'b0;
    flush_pc_i = '0;

    for (logic [31:0] a = 32'h0; a <= 32'h20; a += 4) sb.push_back(a);
`ifdef IF_DELAY_SLOT_EN
    sb.push_back(32'h24);
`endif
    for (logic [31:0] a = 32'h100; a <= 32'h110; a += 4) sb.push_back(a);
    for (logic [31:0] a = 32'h180; a <= 32'h18C; a += 4) sb.push_back(a);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", {31'b0, imem_ce_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'd0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);

    rst = 1'b0;
    #1;
    chk("rel_c0_ce", {31'b0, imem_ce_o}, 32'd1);
    chk("rel_c0_addr", imem_addr_o, 32'h0);
    @(posedge clk); #1;
    chk("rel_c1_ce", {31'b0, imem_ce_o}, 32'd1);
    chk("rel_c1_addr", imem_addr_o, 32'h4);
    @(posedge clk); #1;
    chk("rel_c2_addr", imem_addr_o, 32'h8);
    chk("rel_c2_valid", {31'b0, id_valid_o}, 32'd1);
    chk("rel_c2_pc", id_pc_o, 32'h0);

    begin
      logic stall_done, br_done;
      stall_done = 1'b0;
      br_done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        flush_i = 1'b0;
        if (id_valid_o && id_pc_o == 32'h10 && !stall_done) begin
          id_ready_i = 1'b0;
          stall_done = 1'b1;
          for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            chk("stall_ce", {31'b0, imem_ce_o}, 32'd0);
            chk("stall_pc", id_pc_o, 32'h10);
          end
          id_ready_i = 1'b1;
        end else if (id_valid_o && id_pc_o == 32'h20 && !br_done) begin
          br_done = 1'b1;
          branch_flag_i = 1'b1;
          branch_target_address_i = 32'h100;
        end else if (id_valid_o && id_pc_o == 32'h110) begin
          branch_flag_i = 1'b1;
          branch_target_address_i = 32'h200;
          flush_i = 1'b1;
          flush_pc_i = 32'h180;
          @(posedge clk); #1;
          branch_flag_i = 1'b0;
          flush_i = 1'b0;
          chk("flush_valid", {31'b0, id_valid_o}, 32'd0);
          chk("flush_ce", {31'b0, imem_ce_o}, 32'd1);
          chk("flush_addr", imem_addr_o, 32'h180);
          repeat (2) @(posedge clk);
          #1;
          chk("flush_lat_pc", id_valid_o ? id_pc_o : 32'hFFFF_FFFF, 32'h180);
        end else if (id_valid_o && id_pc_o == 32'h190) begin
          id_ready_i = 1'b0;
          chk("sb_drained", sb.size(), 32'd0);
          repeat (2) @(posedge clk);
          #1;
          rst = 1'b1;
          sb.delete();
          @(posedge clk); #1;
          chk("pulse_ce", {31'b0, imem_ce_o}, 32'd0);
          chk("pulse_addr", imem_addr_o, 32'h0);
          chk("pulse_valid", {31'b0, id_valid_o}, 32'd0);
          chk("pulse_pc", id_pc_o, 32'h0);
          chk("pulse_inst", id_inst_o, 32'h0);
          rst = 1'b0;
          id_ready_i = 1'b1;
          for (logic [31:0] a = 32'h0; a <= 32'hC; a += 4) sb.push_back(a);
          #1;
          chk("restart_ce", {31'b0, imem_ce_o}, 32'd1);
          chk("restart_addr", imem_addr_o, 32'h0);
          for (int w = 0; w < 50 && sb.size() != 0; w++) begin
            @(posedge clk); #1;
          end
          mon_en = 1'b0;
          chk("restart_drained", sb.size(), 32'd0);
          done = 1'b1;
        end
      end
    end

    if (!done) begin
      nvec++;
      nmis++;
      $display("FAIL timeout: got done=0, expected done=1");
    end
    chk("target_0x200_fetched", {31'b0, saw_200}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS core. It generates the PC, drives the synchronous instruction memory, and buffers returned words in a small in-order queue. It presents one `{pc, inst}` pair per cycle to the decode stage. It also applies branch redirects from decode with MIPS delay-slot semantics, plus full flushes from the pipeline controller.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QDEPTH`, default 2: instruction queue depth; power of two, ≥2.

Ports:
- `clk`  in  1: clock, all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `imem_ce_o`  out  1: fetch request.
- `imem_addr_o`  out  32: fetch address (word aligned).
- `imem_rdata_i`  in  32: instruction, valid exactly 1 cycle after a `imem_ce_o` cycle.
- `id_valid_o`  out  1: `id_pc_o`/`id_inst_o` hold a live instruction.
- `id_pc_o`  out  32: PC of the presented instruction.
- `id_inst_o`  out  32: presented instruction; 0 (NOP) when not valid.
- `id_ready_i`  in  1: decode accepts (deasserted on stall).
- `branch_flag_i`  in  1: presented instruction is a taken branch/jump.
- `branch_target_address_i`  in  32: branch target.
- `flush_i`  in  1: controller flush.
- `flush_pc_i`  in  32: restart address on flush.

## Operation
- Fetch PC register `fpc`, reset value `RESET_PC`.
- Issue rule: `imem_ce_o = !rst && (count + inflight − pop < QDEPTH)`, where `pop = id_valid_o && id_ready_i`.
- On issue, `fpc` advances by 4. The returned word enters the queue tail, tagged with its PC, unless it is marked killed.
- The head of the queue drives the ID outputs. Pop happens on the `id_valid_o && id_ready_i` cycle.
- Branch: `branch_flag_i` is sampled only on a pop cycle.
  - The delay slot is the first instruction after the branch in program order. It is kept whether it sits in the queue, is in flight, or is not yet issued.
  - Every later queue entry is discarded, and a later in-flight word is killed.
  - If the delay slot has already been issued, `fpc` becomes the target on the next cycle.
  - Otherwise the next issue is the delay slot at branch PC+4, followed by the target.
- Flush:
  - Empties the queue and kills any in-flight word.
  - Sets `fpc` to `flush_pc_i`.
  - Drops any pending redirect.
  - Forces `id_valid_o` low in the following cycle.
- Simultaneous flush and branch: the flush wins and the branch is ignored.
- Simultaneous push and pop on a full queue is legal.
- `branch_flag_i` asserted with `id_valid_o` low is ignored.

## Timing
- Reset values: `imem_ce_o`=0, `imem_addr_o`=`RESET_PC`, `id_valid_o`=0, `id_pc_o`=0, `id_inst_o`=0; queue empty; no pending redirect.
- In the first cycle after `rst` falls, `imem_ce_o`=1 and `imem_addr_o`=`RESET_PC`.
- Latency: a request issued in cycle N has its data arrive in N+1 and is presented on the ID outputs in N+2 (registered).
- Throughput: 1 instruction per cycle with `QDEPTH`=2 and `id_ready_i` held high.
- Stall: outputs stay frozen while `id_ready_i`=0. Issue stops when the queue plus in-flight count reaches `QDEPTH`, so no word is ever lost.
- Branch to target fetch: the target is presented ≥2 cycles after the delay slot is presented. There are no bubbles between branch and delay slot if the slot is already queued.
- `rst` asserted mid-operation: all state returns to reset values on the next edge. A word returning from memory in that cycle is dropped.

## Configuration
- `IF_DELAY_SLOT_EN` defined: delay-slot semantics as described above.
- `IF_DELAY_SLOT_EN` undefined: a taken branch discards all queued and in-flight instructions and fetches the target next, with no delay slot.

## Structure
- The shared package holds `InitialPc`, `ZeroWord`, the NOP encoding, and the instruction/address bus widths.
- Sub-module `if_fifo`: parameterised `{pc, inst}` queue with push, pop, clear and "keep first N" truncate, plus count output.
- Kill/redirect logic and `fpc` live in `if_stage`.

## Test plan
- **Reset release, `id_ready_i`=1:** addresses 0, 4, 8 issued on consecutive cycles. The ID outputs show pc 0 in the 2nd cycle after release, then 4, then 8, back to back.
- **Stall for 5 cycles with queue full:** `imem_ce_o` drops after the queue fills; the ID outputs hold pc 0x10. On release, pcs 0x14 and 0x18 follow with no loss or duplication.
- **Branch at pc 0x20 to target 0x100, delay slot in flight (`IF_DELAY_SLOT_EN` defined):** the presented sequence is 0x20, 0x24, 0x100; 0x28 is never presented.
- **Same branch with `IF_DELAY_SLOT_EN` undefined:** the sequence is 0x20, 0x100.
- **`flush_i` with `flush_pc_i`=0x180 in the same cycle as a branch pop:** `id_valid_o`=0 next cycle, 0x180 is presented 2 cycles after the restart issue, and the branch target is never fetched.
- **`rst` pulsed while the queue holds 2 entries:** all outputs return to reset values, and the fetch restarts at `RESET_PC`.
